// File: rtl/hc595_clk_if.sv
// Pin bundle for the hc595_clk serial-to-parallel register (control inputs plus cascade out).
// Latency: none, wires only.
// Backpressure: none; pins are levels sampled by the device on its system clock.
interface hc595_clk_if;
   logic p14;  // DS, serial data in
   logic p11;  // SHCP, shift clock (rising edge)
   logic p12;  // STCP, storage clock (rising edge)
   logic p10;  // MR#, active-low shift-register clear
   logic p13;  // OE#, active-low output enable
   logic p9;   // Q7S, serial cascade out

   // Driver side: the board/bench that toggles the pins.
   modport master (output p14, p11, p12, p10, p13, input p9);
   // Device side.
   modport slave  (input p14, p11, p12, p10, p13, output p9);
endinterface

// File: rtl/hc595_clk.sv
// 74HC595 model on a system clock: 8-bit serial shift register, storage register, 3-state Q bus, cascade out.
// Latency: pin edge to register 1 clk (3 clk with HC595_INSYNC_EN defined); OE# to Q is combinational.
// Backpressure: none; each 0->1 pin transition held at least 1 clk yields exactly one action.
// Optional macro HC595_INSYNC_EN: 2-flop synchronizers on p10/p11/p12/p14 for asynchronous pins.
module hc595_clk #(
   parameter logic [7:0] STORAGE_INIT = 8'h00
) (
   input  logic        clk,
   input  logic        rst,
   hc595_clk_if.slave  pins,
   output wire         p15,
   output wire         p1,
   output wire         p2,
   output wire         p3,
   output wire         p4,
   output wire         p5,
   output wire         p6,
   output wire         p7
);

   // Pin copies actually used by the register logic.
   logic ds;
   logic shcp;
   logic stcp;
   logic mr_n;

`ifdef HC595_INSYNC_EN
   // Bit order {ds, stcp, shcp, mr_n}; clocks and MR# idle high so release is edge-free.
   localparam logic [3:0] SYNC_RST = 4'b0111;

   logic [3:0] sync1_q, sync1_d;
   logic [3:0] sync2_q, sync2_d;

   // Two-stage synchronizer next-state: data moves one stage per clk.
   always_comb begin
      sync1_d = {pins.p14, pins.p12, pins.p11, pins.p10};
      sync2_d = sync1_q;
   end

   // Synchronizer flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= SYNC_RST;
         sync2_q <= SYNC_RST;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   assign {ds, stcp, shcp, mr_n} = sync2_q;
`else
   // Pins are assumed synchronous to clk and used directly.
   assign {ds, stcp, shcp, mr_n} = {pins.p14, pins.p12, pins.p11, pins.p10};
`endif

   logic [7:0] sh_q, sh_d;
   logic [7:0] st_q, st_d;
   logic       prev_shcp_q, prev_shcp_d;
   logic       prev_stcp_q, prev_stcp_d;
   logic       shcp_rise;
   logic       stcp_rise;

   // Edge detection and register next-state. The store reads sh_q (the value before this
   // cycle's shift or clear), reproducing the real part's one-stage skew.
   always_comb begin
      shcp_rise   = shcp & ~prev_shcp_q;
      stcp_rise   = stcp & ~prev_stcp_q;
      prev_shcp_d = shcp;
      prev_stcp_d = stcp;
      sh_d        = sh_q;
      st_d        = st_q;
      if (stcp_rise) begin
         st_d = sh_q;
      end
      if (!mr_n) begin
         sh_d = 8'h00;                 // clear wins over a coincident shift
      end else if (shcp_rise) begin
         sh_d = {sh_q[6:0], ds};
      end
   end

   // State registers; edge-detect flops reset high so a pin held high through reset is not an edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_q        <= 8'h00;
         st_q        <= STORAGE_INIT;
         prev_shcp_q <= 1'b1;
         prev_stcp_q <= 1'b1;
      end else begin
         sh_q        <= sh_d;
         st_q        <= st_d;
         prev_shcp_q <= prev_shcp_d;
         prev_stcp_q <= prev_stcp_d;
      end
   end

   // Parallel outputs float while OE# is high; cascade output is always driven.
   assign p15 = pins.p13 ? 1'bz : st_q[0];
   assign p1  = pins.p13 ? 1'bz : st_q[1];
   assign p2  = pins.p13 ? 1'bz : st_q[2];
   assign p3  = pins.p13 ? 1'bz : st_q[3];
   assign p4  = pins.p13 ? 1'bz : st_q[4];
   assign p5  = pins.p13 ? 1'bz : st_q[5];
   assign p6  = pins.p13 ? 1'bz : st_q[6];
   assign p7  = pins.p13 ? 1'bz : st_q[7];
   assign pins.p9 = sh_q[7];

endmodule

// File: tb/tb_hc595_clk.sv
// Directed bench for hc595_clk: reset, serial load, coincident edges, MR#, OE#, mid-run reset.
// Q lines carry pull-ups, so a floating bus reads 8'hFF.
module tb_hc595_clk;

   localparam logic [7:0] STORAGE_INIT = 8'h00;
`ifdef HC595_INSYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic clk;
   logic rst;
   int   n_pass;
   int   n_total;

   hc595_clk_if pins ();

   wire p15, p1, p2, p3, p4, p5, p6, p7;
   pullup (p15);
   pullup (p1);
   pullup (p2);
   pullup (p3);
   pullup (p4);
   pullup (p5);
   pullup (p6);
   pullup (p7);
   wire [7:0] q = {p7, p6, p5, p4, p3, p2, p1, p15};

   hc595_clk #(.STORAGE_INIT(STORAGE_INIT)) dut (
      .clk  (clk),
      .rst  (rst),
      .pins (pins),
      .p15  (p15),
      .p1   (p1),
      .p2   (p2),
      .p3   (p3),
      .p4   (p4),
      .p5   (p5),
      .p6   (p6),
      .p7   (p7)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic shift_bit(input logic b);
      pins.p14 = b;
      pins.p11 = 1'b1;
      tick(1);
      pins.p11 = 1'b0;
      tick(1);
   endtask

   task automatic shift_byte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) shift_bit(v[i]);
   endtask

   task automatic store_pulse();
      pins.p12 = 1'b1;
      tick(1);
      pins.p12 = 1'b0;
      tick(1);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      pins.p13 = 1'b0;
      pins.p10 = 1'b1;
      pins.p11 = 1'b1;
      pins.p12 = 1'b1;
      pins.p14 = 1'b1;
      tick(2);
      n_total++;
      if (q !== STORAGE_INIT) $display("FAIL reset_q: got %h expected %h", q, STORAGE_INIT);
      else n_pass++;
      n_total++;
      if (pins.p9 !== 1'b0) $display("FAIL reset_p9: got %b expected 0", pins.p9);
      else n_pass++;
      // Release with clocks held high: a spurious shift would walk a 1 up to Q7S.
      rst = 1'b0;
      tick(10);
      pins.p11 = 1'b0;
      pins.p12 = 1'b0;
      pins.p14 = 1'b0;
      tick(LAT + 1);
      for (int i = 0; i < 7; i++) shift_bit(1'b0);
      store_pulse();
      tick(LAT);
      n_total++;
      if (q !== 8'h00) $display("FAIL release_q: got %h expected 00", q);
      else n_pass++;
      n_total++;
      if (pins.p9 !== 1'b0) $display("FAIL release_p9: got %b expected 0", pins.p9);
      else n_pass++;
   endtask

   task automatic test_serial_load();
      shift_byte(8'hB2);
      pins.p12 = 1'b1;
      tick(LAT - 1);
      n_total++;
      if (q !== 8'h00) $display("FAIL serial_pre_q: got %h expected 00", q);
      else n_pass++;
      tick(1);
      n_total++;
      if (q !== 8'hB2) $display("FAIL serial_q: got %h expected b2", q);
      else n_pass++;
      pins.p12 = 1'b0;
      tick(LAT + 1);
      n_total++;
      if (pins.p9 !== 1'b1) $display("FAIL serial_p9: got %b expected 1", pins.p9);
      else n_pass++;
   endtask

   task automatic test_simultaneous();
      shift_byte(8'h0F);
      pins.p14 = 1'b1;
      pins.p11 = 1'b1;
      pins.p12 = 1'b1;
      tick(1);
      pins.p11 = 1'b0;
      pins.p12 = 1'b0;
      tick(LAT + 1);
      n_total++;
      if (q !== 8'h0F) $display("FAIL simul_st: got %h expected 0f", q);
      else n_pass++;
      store_pulse();
      tick(LAT);
      n_total++;
      if (q !== 8'h1F) $display("FAIL simul_sh: got %h expected 1f", q);
      else n_pass++;
   endtask

   task automatic test_mr();
      shift_byte(8'hA5);
      store_pulse();
      shift_byte(8'hFF);
      tick(LAT);
      pins.p10 = 1'b0;
      pins.p14 = 1'b1;
      pins.p11 = 1'b1;
      tick(1);
      pins.p10 = 1'b1;
      pins.p11 = 1'b0;
      tick(LAT + 1);
      n_total++;
      if (pins.p9 !== 1'b0) $display("FAIL mr_p9: got %b expected 0", pins.p9);
      else n_pass++;
      n_total++;
      if (q !== 8'hA5) $display("FAIL mr_q_hold: got %h expected a5", q);
      else n_pass++;
      store_pulse();
      tick(LAT);
      n_total++;
      if (q !== 8'h00) $display("FAIL mr_sh_clear: got %h expected 00", q);
      else n_pass++;
      // Clear coincident with a store: storage takes the pre-clear contents.
      shift_byte(8'h5A);
      tick(LAT);
      pins.p10 = 1'b0;
      pins.p12 = 1'b1;
      tick(1);
      pins.p10 = 1'b1;
      pins.p12 = 1'b0;
      tick(LAT + 1);
      n_total++;
      if (q !== 8'h5A) $display("FAIL mr_store_old: got %h expected 5a", q);
      else n_pass++;
      store_pulse();
      tick(LAT);
      n_total++;
      if (q !== 8'h00) $display("FAIL mr_store_clear: got %h expected 00", q);
      else n_pass++;
   endtask

   task automatic test_oe();
      shift_byte(8'h3C);
      store_pulse();
      shift_bit(1'b1);
      shift_bit(1'b1);
      tick(LAT);
      n_total++;
      if (q !== 8'h3C) $display("FAIL oe_on_q: got %h expected 3c", q);
      else n_pass++;
      n_total++;
      if (pins.p9 !== 1'b1) $display("FAIL oe_on_p9: got %b expected 1", pins.p9);
      else n_pass++;
      pins.p13 = 1'b1;
      #1;
      n_total++;
      if (q !== 8'hFF) $display("FAIL oe_off_q: got %h expected ff (floating)", q);
      else n_pass++;
      n_total++;
      if (pins.p9 !== 1'b1) $display("FAIL oe_off_p9: got %b expected 1", pins.p9);
      else n_pass++;
      pins.p13 = 1'b0;
      #1;
      n_total++;
      if (q !== 8'h3C) $display("FAIL oe_reon_q: got %h expected 3c", q);
      else n_pass++;
      pins.p13 = 1'b1;
      #1;
      n_total++;
      if (q !== 8'hFF) $display("FAIL oe_reoff_q: got %h expected ff (floating)", q);
      else n_pass++;
      pins.p13 = 1'b0;
      tick(1);
   endtask

   task automatic test_mid_reset();
      shift_bit(1'b1);
      shift_bit(1'b1);
      shift_bit(1'b1);
      shift_bit(1'b1);
      rst = 1'b1;
      #1;
      n_total++;
      if (q !== STORAGE_INIT) $display("FAIL midrst_q: got %h expected %h", q, STORAGE_INIT);
      else n_pass++;
      n_total++;
      if (pins.p9 !== 1'b0) $display("FAIL midrst_p9: got %b expected 0", pins.p9);
      else n_pass++;
      tick(2);
      rst = 1'b0;
      tick(2);
      store_pulse();
      tick(LAT);
      n_total++;
      if (q !== 8'h00) $display("FAIL midrst_sh: got %h expected 00", q);
      else n_pass++;
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      rst      = 1'b1;
      pins.p10 = 1'b1;
      pins.p11 = 1'b1;
      pins.p12 = 1'b1;
      pins.p13 = 1'b0;
      pins.p14 = 1'b0;
      test_reset();
      test_serial_load();
      test_simultaneous();
      test_mr();
      test_oe();
      test_mid_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
